// File: rtl/in_buf_wr_ctrl.sv
// in_buf_wr_ctrl
// Input-buffer write controller for the systolic array. Takes SYS_ROW-wide row
// beats over a valid/ready stream and turns each accepted beat into one
// registered per-lane SRAM write. Element chunks advance fastest, then rows,
// then tiles. The final partial chunk of a row is lane-masked.
//
// Optional feature macro: IN_BUF_PINGPONG_EN
//   defined   : two banks, bank bit is the MSB of in_wr_addr, bank toggles per tile
//   undefined : single bank 0; every tile after the first waits for bank_release[0]
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cfg_start             single-cycle job start (honoured in IDLE only)
//   cfg_num_common/rows/tiles  job geometry
//   in_valid/in_ready/in_data  beat stream
//   in_wr_en/addr/data    registered per-lane write port
//   bank_release          consumer frees bank b (bit b)
//   bank_full             bank holds an unconsumed tile
//   tile_done/tile_bank   pulse with the last write of a tile, and its bank
//   job_done              pulse with the last tile_done of the job
//   cfg_err               pulse on rejected configuration
//   busy                  controller not idle
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for cfg_start
// FILL      | accepting beats into the current bank
// WAIT_BANK | current bank still full, holding off the stream
module in_buf_wr_ctrl #(
  parameter int SYS_ROW    = 16,
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int ACCUM_SIZE = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic [15:0]                         cfg_num_common,
  input  logic [15:0]                         cfg_num_rows,
  input  logic [15:0]                         cfg_num_tiles,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SYS_ROW-1:0][DATA_WIDTH-1:0]  in_data,
  output logic [SYS_ROW-1:0]                  in_wr_en,
  output logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]  in_wr_addr,
  output logic [SYS_ROW-1:0][DATA_WIDTH-1:0]  in_wr_data,
  input  logic [1:0]                          bank_release,
  output logic [1:0]                          bank_full,
  output logic                                tile_done,
  output logic                                tile_bank,
  output logic                                job_done,
  output logic                                cfg_err,
  output logic                                busy
);

  localparam int ACCUM_ROW = ACCUM_SIZE / SYS_COL;
`ifdef IN_BUF_PINGPONG_EN
  localparam int LOCAL_AW = ADDR_WIDTH - 1;
  localparam bit PINGPONG = 1'b1;
`else
  localparam int LOCAL_AW = ADDR_WIDTH;
  localparam bit PINGPONG = 1'b0;
`endif
  localparam int MAX_CHUNKS = (2**LOCAL_AW) / ACCUM_ROW;

  typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_t;

  state_t state_q, state_d;
  logic [15:0] num_common_q, num_common_d;
  logic [15:0] chunks_q, chunks_d;
  logic [15:0] num_rows_q, num_rows_d;
  logic [15:0] num_tiles_q, num_tiles_d;
  logic [15:0] chunk_q, chunk_d;
  logic [15:0] row_q, row_d;
  logic [15:0] tile_q, tile_d;
  logic        bank_q, bank_d;
  logic [1:0]  bank_full_q, bank_full_d;
  logic [SYS_ROW-1:0]                 wr_en_q, wr_en_d;
  logic [SYS_ROW-1:0][ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic tile_done_q, tile_done_d;
  logic tile_bank_q, tile_bank_d;
  logic job_done_q, job_done_d;
  logic cfg_err_q, cfg_err_d;

  logic [31:0]           chunks_w;
  logic                  cfg_bad;
  logic [1:0]            rel;
  logic [SYS_ROW-1:0]    lane_en;
  logic [LOCAL_AW-1:0]   laddr;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  nxt_bank;

  always_comb begin
    state_d      = state_q;
    num_common_d = num_common_q;
    chunks_d     = chunks_q;
    num_rows_d   = num_rows_q;
    num_tiles_d  = num_tiles_q;
    chunk_d      = chunk_q;
    row_d        = row_q;
    tile_d       = tile_q;
    bank_d       = bank_q;
    wr_en_d      = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    tile_done_d  = 1'b0;
    tile_bank_d  = tile_bank_q;
    job_done_d   = 1'b0;
    cfg_err_d    = 1'b0;

    chunks_w = (32'(cfg_num_common) + 32'(SYS_ROW - 1)) / 32'(SYS_ROW);
    cfg_bad  = (cfg_num_common == 16'd0) || (cfg_num_rows == 16'd0) ||
               (32'(cfg_num_rows) > 32'(ACCUM_ROW)) ||
               (chunks_w > 32'(MAX_CHUNKS)) || (cfg_num_tiles == 16'd0);

    // Releases are applied first so that a tile-end set below overrides a
    // same-cycle release of that bank.
    rel         = bank_release & {PINGPONG, 1'b1};
    bank_full_d = bank_full_q & ~rel;

    for (int i = 0; i < SYS_ROW; i++) begin
      lane_en[i] = (32'(chunk_q) * 32'(SYS_ROW) + 32'(i)) < 32'(num_common_q);
    end
    laddr = LOCAL_AW'(32'(chunk_q) * 32'(ACCUM_ROW) + 32'(row_q));
`ifdef IN_BUF_PINGPONG_EN
    addr     = {bank_q, laddr};
    nxt_bank = ~bank_q;
`else
    addr     = laddr;
    nxt_bank = bank_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            num_common_d = cfg_num_common;
            chunks_d     = 16'(chunks_w);
            num_rows_d   = cfg_num_rows;
            num_tiles_d  = cfg_num_tiles;
            chunk_d      = '0;
            row_d        = '0;
            tile_d       = '0;
            state_d      = bank_full_d[bank_q] ? WAIT_BANK : FILL;
          end
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en_d = lane_en;
          for (int i = 0; i < SYS_ROW; i++) begin
            wr_addr_d[i] = addr;
            if (lane_en[i]) wr_data_d[i] = in_data[i];
          end
          if (chunk_q == chunks_q - 16'd1) begin
            chunk_d = '0;
            if (row_q == num_rows_q - 16'd1) begin
              row_d               = '0;
              tile_d              = tile_q + 16'd1;
              tile_done_d         = 1'b1;
              tile_bank_d         = bank_q;
              bank_full_d[bank_q] = 1'b1;
              bank_d              = nxt_bank;
              if (tile_q + 16'd1 == num_tiles_q) begin
                job_done_d = 1'b1;
                state_d    = IDLE;
              end else begin
                state_d = bank_full_d[nxt_bank] ? WAIT_BANK : FILL;
              end
            end else begin
              row_d = row_q + 16'd1;
            end
          end else begin
            chunk_d = chunk_q + 16'd1;
          end
        end
      end
      WAIT_BANK: begin
        if (!bank_full_d[bank_q]) state_d = FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      num_common_q <= '0;
      chunks_q     <= '0;
      num_rows_q   <= '0;
      num_tiles_q  <= '0;
      chunk_q      <= '0;
      row_q        <= '0;
      tile_q       <= '0;
      bank_q       <= 1'b0;
      bank_full_q  <= '0;
      wr_en_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      tile_done_q  <= 1'b0;
      tile_bank_q  <= 1'b0;
      job_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_common_q <= num_common_d;
      chunks_q     <= chunks_d;
      num_rows_q   <= num_rows_d;
      num_tiles_q  <= num_tiles_d;
      chunk_q      <= chunk_d;
      row_q        <= row_d;
      tile_q       <= tile_d;
      bank_q       <= bank_d;
      bank_full_q  <= bank_full_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      tile_done_q  <= tile_done_d;
      tile_bank_q  <= tile_bank_d;
      job_done_q   <= job_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign in_ready   = (state_q == FILL);
  assign busy       = (state_q != IDLE);
  assign in_wr_en   = wr_en_q;
  assign in_wr_addr = wr_addr_q;
  assign in_wr_data = wr_data_q;
  assign bank_full  = bank_full_q;
  assign tile_done  = tile_done_q;
  assign tile_bank  = tile_bank_q;
  assign job_done   = job_done_q;
  assign cfg_err    = cfg_err_q;

endmodule
